// File: rtl/fractal_stream_to_axis.sv
// Pixel stream to AXI4-Stream bridge with a first-word-fall-through FIFO and sticky overflow flag.
// Optional frame-structure checker enabled by defining FRACTAL_FRAME_CHECK_EN.
module fractal_stream_to_axis #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FRAME_WIDTH  = 1920,
  parameter int unsigned FRAME_HEIGHT = 1080
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          frame_start_in,
  input  logic                          line_end_in,
  input  logic                          data_enable_in,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_error,
  input  logic                          err_clear
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 2;
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 4");
  end
  if (FRAME_WIDTH < 2 || FRAME_HEIGHT < 1) begin : g_bad_frame
    $error("FRAME_WIDTH must be at least 2 and FRAME_HEIGHT at least 1");
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          full, xfer, wr_en, drop;

  assign full  = (level_q == LevelFull);
  assign xfer  = m_axis_tvalid && m_axis_tready;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign wr_en = data_enable_in && (!full || xfer);
  assign drop  = data_enable_in && full && !xfer;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (xfer)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, xfer})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {frame_start_in, line_end_in, data_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign m_axis_tvalid = (level_q != '0);
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];
  assign fifo_level = level_q;

  // A new set in the same cycle as err_clear wins.
  always_comb begin
    overflow_d = overflow_q;
    if (err_clear) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef FRACTAL_FRAME_CHECK_EN
  localparam int unsigned XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [XW-1:0] XLast = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(FRAME_HEIGHT - 1);

  logic [XW-1:0] x_q, x_d, pos_x;
  logic [YW-1:0] y_q, y_d, pos_y;
  logic          seen_q, seen_d;
  logic          ferr_set;
  logic          frame_error_q, frame_error_d;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    seen_d   = seen_q;
    ferr_set = 1'b0;
    // Position of the current beat; frame start forces it to the origin.
    pos_x    = frame_start_in ? '0 : x_q;
    pos_y    = frame_start_in ? '0 : y_q;
    if (data_enable_in) begin
      if (frame_start_in && seen_q && (x_q != '0 || y_q != '0)) ferr_set = 1'b1;
      if (line_end_in && pos_x != XLast)                        ferr_set = 1'b1;
      if (!line_end_in && pos_x == XLast)                       ferr_set = 1'b1;
      if (frame_start_in) seen_d = 1'b1;
      if (line_end_in || pos_x == XLast) begin
        x_d = '0;
        y_d = (pos_y == YLast) ? '0 : pos_y + 1'b1;
      end else begin
        x_d = pos_x + 1'b1;
        y_d = pos_y;
      end
    end
  end

  always_comb begin
    frame_error_d = frame_error_q;
    if (err_clear) frame_error_d = 1'b0;
    if (ferr_set)  frame_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q           <= '0;
      y_q           <= '0;
      seen_q        <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      seen_q        <= seen_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign frame_error = frame_error_q;
`else
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_fractal_stream_to_axis.sv
// Directed bench for fractal_stream_to_axis: 4x2 frame, overflow, full pass-through,
// stall stability, frame error (when the checker is built in) and mid-frame reset.
module tb_fractal_stream_to_axis;

  localparam int unsigned DW = 24;
  localparam int unsigned FD = 16;
  localparam int unsigned LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] data_in;
  logic          frame_start_in, line_end_in, data_enable_in;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic [LW-1:0] fifo_level;
  logic          overflow, frame_error, err_clear;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] q[$];

  fractal_stream_to_axis #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (FD),
    .FRAME_WIDTH (4),
    .FRAME_HEIGHT(2)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .data_in       (data_in),
    .frame_start_in(frame_start_in),
    .line_end_in   (line_end_in),
    .data_enable_in(data_enable_in),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .frame_error   (frame_error),
    .err_clear     (err_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic en, input logic [DW-1:0] d, input logic fs, input logic le);
    data_enable_in = en;
    data_in        = d;
    frame_start_in = fs;
    line_end_in    = le;
  endtask

  // Pops the reference queue against the DUT with tready held high.
  task automatic drain(input string tag);
    int guard = 0;
    beat(1'b0, '0, 1'b0, 1'b0);
    m_axis_tready = 1'b1;
    while (q.size() > 0 && guard < 64) begin
      chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
      chk({tag, "_tdata"}, 32'(m_axis_tdata), 32'(q.pop_front()));
      step();
      guard++;
    end
    chk({tag, "_empty"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_level0"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    logic          stalled;
    logic [DW-1:0] held;
    logic          exp_ferr;

    resetn        = 1'b0;
    m_axis_tready = 1'b0;
    err_clear     = 1'b0;
    beat(1'b0, '0, 1'b0, 1'b0);
    #3;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    step();
    resetn = 1'b1;
    step();

    // 1: 4x2 frame at full rate, each beat visible one cycle later.
    m_axis_tready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      beat(1'b1, DW'(k), k == 1, k == 4 || k == 8);
      step();
      chk("s1_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("s1_tdata", 32'(m_axis_tdata), 32'(k));
      chk("s1_tuser", 32'(m_axis_tuser), 32'(k == 1));
      chk("s1_tlast", 32'(m_axis_tlast), 32'(k == 4 || k == 8));
      chk("s1_level", 32'(fifo_level), 32'd1);
    end
    beat(1'b0, '0, 1'b0, 1'b0);
    step();
    chk("s1_tvalid_end", 32'(m_axis_tvalid), 32'd0);
    chk("s1_ferr", 32'(frame_error), 32'd0);

    // 5: line end at x=2 of a 4-wide frame.
    beat(1'b1, 24'h11, 1'b1, 1'b0);
    step();
    beat(1'b1, 24'h12, 1'b0, 1'b0);
    step();
    chk("s5_ferr_before", 32'(frame_error), 32'd0);
    beat(1'b1, 24'h13, 1'b0, 1'b1);
    step();
`ifdef FRACTAL_FRAME_CHECK_EN
    exp_ferr = 1'b1;
`else
    exp_ferr = 1'b0;
`endif
    chk("s5_ferr_set", 32'(frame_error), 32'(exp_ferr));
    beat(1'b0, '0, 1'b0, 1'b0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("s5_ferr_clr", 32'(frame_error), 32'd0);
    step();
    chk("s5_empty", 32'(fifo_level), 32'd0);

    // 2: 17 beats into a stalled 16-deep FIFO; the 17th is dropped.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      beat(1'b1, DW'(24'h100 + i), 1'b0, 1'b0);
      if (i < 16) q.push_back(DW'(24'h100 + i));
      step();
      chk("s2_level", 32'(fifo_level), (i < 16) ? 32'(i + 1) : 32'd16);
      chk("s2_overflow", 32'(overflow), 32'(i == 16));
    end
    drain("s2");
    chk("s2_overflow_sticky", 32'(overflow), 32'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("s2_overflow_clr", 32'(overflow), 32'd0);

    // 3: full FIFO with simultaneous write and transfer for 5 cycles.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, DW'(24'h200 + i), 1'b0, 1'b0);
      q.push_back(DW'(24'h200 + i));
      step();
    end
    chk("s3_full", 32'(fifo_level), 32'd16);
    m_axis_tready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("s3_head", 32'(m_axis_tdata), 32'(q.pop_front()));
      beat(1'b1, DW'(24'h300 + j), 1'b0, 1'b0);
      q.push_back(DW'(24'h300 + j));
      step();
      chk("s3_level", 32'(fifo_level), 32'd16);
      chk("s3_overflow", 32'(overflow), 32'd0);
    end
    drain("s3");

    // 4: tready toggles while input runs every cycle.
    stalled = 1'b0;
    held    = '0;
    for (int i = 0; i < 12; i++) begin
      m_axis_tready = (i % 2) == 1;
      if (stalled) chk("s4_stable", 32'(m_axis_tdata), 32'(held));
      if (m_axis_tvalid && m_axis_tready) chk("s4_order", 32'(m_axis_tdata), 32'(q.pop_front()));
      stalled = m_axis_tvalid && !m_axis_tready;
      held    = m_axis_tdata;
      beat(1'b1, DW'(24'hA00 + i), 1'b0, 1'b0);
      q.push_back(DW'(24'hA00 + i));
      step();
    end
    drain("s4");

    // 6: asynchronous reset with 7 beats buffered.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      beat(1'b1, DW'(24'h500 + i), 1'b0, 1'b0);
      step();
    end
    beat(1'b0, '0, 1'b0, 1'b0);
    chk("s6_level7", 32'(fifo_level), 32'd7);
    #2;
    resetn = 1'b0;
    #1;
    chk("s6_async_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("s6_async_level", 32'(fifo_level), 32'd0);
    step();
    resetn = 1'b1;
    step();
    chk("s6_post_tvalid", 32'(m_axis_tvalid), 32'd0);
    beat(1'b1, 24'h777, 1'b0, 1'b0);
    step();
    beat(1'b0, '0, 1'b0, 1'b0);
    chk("s6_new_tdata", 32'(m_axis_tdata), 32'h777);
    chk("s6_new_level", 32'(fifo_level), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
